// File: rtl/dma_wr_engine.sv
// dma_wr_engine: unpacks wide lane vectors into fixed-length AXI4 INCR
// write bursts, one burst per vector, AW/W/B run in sequence.
module dma_wr_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LANES  = 16,
  parameter int LANE_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            cfg_valid_i,
  input  logic                            cfg_start_i,
  input  logic [ADDR_WIDTH-1:0]           cfg_dst_addr_i,
  input  logic [ADDR_WIDTH-1:0]           cfg_size_i,
  output logic                            cfg_ready_o,
  output logic                            cfg_done_o,
  output logic                            cfg_error_o,
  input  logic                            data_valid_i,
  output logic                            data_ready_o,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] data_i,
  output logic                            axi_awvalid_o,
  input  logic                            axi_awready_i,
  output logic [ADDR_WIDTH-1:0]           axi_awaddr_o,
  output logic [7:0]                      axi_awlen_o,
  output logic [2:0]                      axi_awsize_o,
  output logic [1:0]                      axi_awburst_o,
  output logic                            axi_wvalid_o,
  input  logic                            axi_wready_i,
  output logic [DATA_WIDTH-1:0]           axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0]         axi_wstrb_o,
  output logic                            axi_wlast_o,
  input  logic                            axi_bvalid_i,
  output logic                            axi_bready_o,
  input  logic [1:0]                      axi_bresp_i,
  output logic                            busy_o
);

  localparam int VBITS  = NUM_LANES * LANE_WIDTH;
  localparam int BEATS  = VBITS / DATA_WIDTH;
  localparam int VBYTES = VBITS / 8;
  localparam int STRB   = DATA_WIDTH / 8;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [2:0]            AWSIZE = 3'($clog2(STRB));
  localparam logic [7:0]            AWLEN  = 8'(BEATS - 1);
  localparam logic [BW-1:0]         LAST   = BW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] VB_A   = ADDR_WIDTH'(VBYTES);
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    ADDR,
    WDATA,
    RESP,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]             addr_q;
  logic [ADDR_WIDTH-1:0]             rem_q;
  logic [BW-1:0]                     beat_q;
  logic [BEATS-1:0][DATA_WIDTH-1:0]  buf_q;
  logic                              err_q;
  logic                              cfg_err_q;

  logic start, cfg_bad;
  logic d_hs, aw_hs, w_hs, b_hs;
  logic last_beat, last_burst, resp_bad;

  assign start = (state_q == IDLE) & cfg_valid_i & cfg_start_i;
  assign cfg_bad = (cfg_size_i == '0)
                 | ((cfg_size_i % VB_A) != '0)
                 | ((cfg_dst_addr_i % VB_A) != '0);

  assign d_hs  = (state_q == WAIT_DATA) & data_valid_i;
  assign aw_hs = (state_q == ADDR) & axi_awready_i;
  assign w_hs  = (state_q == WDATA) & axi_wready_i;
  assign b_hs  = (state_q == RESP) & axi_bvalid_i;

  assign last_beat  = (beat_q == LAST);
  assign last_burst = (rem_q == ONE_A);
  assign resp_bad   = (axi_bresp_i != 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start && !cfg_bad) state_d = WAIT_DATA;
      WAIT_DATA: if (data_valid_i) state_d = ADDR;
      ADDR:      if (axi_awready_i) state_d = WDATA;
      WDATA:     if (axi_wready_i && last_beat) state_d = RESP;
      RESP: begin
        if (axi_bvalid_i) begin
          if (resp_bad || last_burst) state_d = FIN;
          else                        state_d = WAIT_DATA;
        end
      end
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      rem_q     <= '0;
      beat_q    <= '0;
      buf_q     <= '0;
      err_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= start & cfg_bad;
      if (start && !cfg_bad) begin
        addr_q <= cfg_dst_addr_i;
        rem_q  <= cfg_size_i / VB_A;
      end
      if (d_hs) buf_q <= data_i;
      if (aw_hs) begin
        beat_q <= '0;
      end else if (w_hs) begin
        beat_q <= last_beat ? '0 : beat_q + BW'(1);
      end
      if (b_hs) begin
        if (resp_bad) begin
          err_q <= 1'b1;
        end else begin
          rem_q <= rem_q - ONE_A;
          if (!last_burst) addr_q <= addr_q + VB_A;
        end
      end
      if (state_q == FIN) err_q <= 1'b0;
    end
  end

  // Every output is a decode of registered state; no ready-to-valid paths.
  assign cfg_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign cfg_done_o    = (state_q == FIN) & ~err_q;
  assign cfg_error_o   = cfg_err_q | ((state_q == FIN) & err_q);
  assign data_ready_o  = (state_q == WAIT_DATA);

  assign axi_awvalid_o = (state_q == ADDR);
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = axi_awvalid_o ? AWLEN : 8'd0;
  assign axi_awsize_o  = AWSIZE;
  assign axi_awburst_o = 2'b01;

  assign axi_wvalid_o  = (state_q == WDATA);
  assign axi_wdata_o   = buf_q[beat_q];
  assign axi_wstrb_o   = '1;
  assign axi_wlast_o   = axi_wvalid_o & last_beat;

  assign axi_bready_o  = (state_q == RESP);

endmodule

// File: tb/tb_dma_wr_engine.sv
// Directed bench for dma_wr_engine: single/multi burst, back-pressure,
// config and response errors, asynchronous reset mid-transfer.
module tb_dma_wr_engine;

  logic         clk;
  logic         rst_n;
  logic         cfg_valid, cfg_start;
  logic [31:0]  cfg_dst, cfg_size;
  logic         cfg_ready, cfg_done, cfg_error;
  logic         data_valid, data_ready;
  logic [511:0] data;
  logic         awvalid, awready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid, wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic         busy;

  int n_chk = 0;
  int n_fail = 0;

  dma_wr_engine dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_valid_i    (cfg_valid),
    .cfg_start_i    (cfg_start),
    .cfg_dst_addr_i (cfg_dst),
    .cfg_size_i     (cfg_size),
    .cfg_ready_o    (cfg_ready),
    .cfg_done_o     (cfg_done),
    .cfg_error_o    (cfg_error),
    .data_valid_i   (data_valid),
    .data_ready_o   (data_ready),
    .data_i         (data),
    .axi_awvalid_o  (awvalid),
    .axi_awready_i  (awready),
    .axi_awaddr_o   (awaddr),
    .axi_awlen_o    (awlen),
    .axi_awsize_o   (awsize),
    .axi_awburst_o  (awburst),
    .axi_wvalid_o   (wvalid),
    .axi_wready_i   (wready),
    .axi_wdata_o    (wdata),
    .axi_wstrb_o    (wstrb),
    .axi_wlast_o    (wlast),
    .axi_bvalid_i   (bvalid),
    .axi_bready_o   (bready),
    .axi_bresp_i    (bresp),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ready"}, cfg_ready, 1'b1);
    chk({tag, " done"}, cfg_done, 1'b0);
    chk({tag, " error"}, cfg_error, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " dready"}, data_ready, 1'b0);
    chk({tag, " awvalid"}, awvalid, 1'b0);
    chk({tag, " awaddr"}, awaddr, 32'h0);
    chk({tag, " awlen"}, awlen, 8'h0);
    chk({tag, " awsize"}, awsize, 3'd2);
    chk({tag, " awburst"}, awburst, 2'd1);
    chk({tag, " wvalid"}, wvalid, 1'b0);
    chk({tag, " wdata"}, wdata, 32'h0);
    chk({tag, " wstrb"}, wstrb, 4'hf);
    chk({tag, " wlast"}, wlast, 1'b0);
    chk({tag, " bready"}, bready, 1'b0);
  endtask

  function automatic logic [511:0] mkvec(input int tag);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = (tag << 16) | i;
    return v;
  endfunction

  task automatic do_start(input logic [31:0] dst, input logic [31:0] sz);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_start = 1'b1;
    cfg_dst   = dst;
    cfg_size  = sz;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    cfg_dst   = 32'hdead_beef;
    cfg_size  = 32'h0;
  endtask

  task automatic do_data(input logic [511:0] v);
    for (int i = 0; i < 50 && !data_ready; i++) @(negedge clk);
    chk("data_ready", data_ready, 1'b1);
    data_valid = 1'b1;
    data       = v;
    @(negedge clk);
    data_valid = 1'b0;
    data       = '0;
    chk("awvalid after data", awvalid, 1'b1);
  endtask

  task automatic do_aw(input logic [31:0] a, input int dly);
    for (int i = 0; i < dly; i++) begin
      chk("awvalid stall", awvalid, 1'b1);
      chk("awaddr stall", awaddr, a);
      @(negedge clk);
    end
    chk("awvalid", awvalid, 1'b1);
    chk("awaddr", awaddr, a);
    chk("awlen", awlen, 8'd15);
    chk("awsize", awsize, 3'd2);
    chk("awburst", awburst, 2'd1);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    chk("wvalid after aw", wvalid, 1'b1);
  endtask

  task automatic do_w(input logic [511:0] v, input bit tog, input int upto);
    for (int b = 0; b < upto; b++) begin
      if (tog && b[0]) begin
        wready = 1'b0;
        chk("wvalid stall", wvalid, 1'b1);
        chk("wdata stall", wdata, v[b*32 +: 32]);
        @(negedge clk);
      end
      chk("wvalid", wvalid, 1'b1);
      chk("wdata", wdata, v[b*32 +: 32]);
      chk("wlast", wlast, b == 15);
      wready = 1'b1;
      @(negedge clk);
    end
    wready = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] r, input int dly);
    chk("bready", bready, 1'b1);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("bready stall", bready, 1'b1);
    end
    bvalid = 1'b1;
    bresp  = r;
    @(negedge clk);
    bvalid = 1'b0;
    bresp  = 2'b00;
  endtask

  logic [511:0] v;

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_start = 1'b0; cfg_dst = '0; cfg_size = '0;
    data_valid = 1'b0; data = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    @(negedge clk);
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // single burst
    v = mkvec(0);
    do_start(32'h2000, 32'd64);
    chk("s busy", busy, 1'b1);
    chk("s cfg_ready", cfg_ready, 1'b0);
    do_data(v);
    do_aw(32'h2000, 0);
    do_w(v, 1'b0, 16);
    do_b(2'b00, 0);
    chk("s done", cfg_done, 1'b1);
    chk("s error", cfg_error, 1'b0);
    @(negedge clk);
    chk("s done clr", cfg_done, 1'b0);
    chk("s ready back", cfg_ready, 1'b1);

    // multi burst
    do_start(32'h2000, 32'd512);
    for (int k = 0; k < 8; k++) begin
      v = mkvec(k + 1);
      do_data(v);
      do_aw(32'h2000 + 32'(k * 64), 0);
      do_w(v, 1'b0, 16);
      do_b(2'b00, 0);
      chk("m done", cfg_done, k == 7);
    end
    @(negedge clk);
    chk("m ready back", cfg_ready, 1'b1);
    chk("m done clr", cfg_done, 1'b0);

    // back-pressure
    v = mkvec(9);
    do_start(32'h0001_0040, 32'd64);
    do_data(v);
    do_aw(32'h0001_0040, 5);
    do_w(v, 1'b1, 16);
    do_b(2'b00, 3);
    chk("bp done", cfg_done, 1'b1);
    @(negedge clk);

    // config errors
    do_start(32'h2000, 32'd0);
    chk("e0 error", cfg_error, 1'b1);
    chk("e0 ready", cfg_ready, 1'b1);
    chk("e0 aw", awvalid, 1'b0);
    @(negedge clk);
    chk("e0 error clr", cfg_error, 1'b0);
    do_start(32'h2000, 32'd100);
    chk("e1 error", cfg_error, 1'b1);
    chk("e1 busy", busy, 1'b0);
    @(negedge clk);
    chk("e1 aw", awvalid, 1'b0);
    do_start(32'h2004, 32'd64);
    chk("e2 error", cfg_error, 1'b1);
    chk("e2 dready", data_ready, 1'b0);
    @(negedge clk);
    chk("e2 aw", awvalid, 1'b0);
    chk("e2 ready", cfg_ready, 1'b1);

    // response error on burst 2 of 3
    do_start(32'h3000, 32'd192);
    v = mkvec(10);
    do_data(v);
    do_aw(32'h3000, 0);
    do_w(v, 1'b0, 16);
    do_b(2'b00, 0);
    chk("r done early", cfg_done, 1'b0);
    v = mkvec(11);
    do_data(v);
    do_aw(32'h3040, 0);
    do_w(v, 1'b0, 16);
    do_b(2'b10, 0);
    chk("r error", cfg_error, 1'b1);
    chk("r done", cfg_done, 1'b0);
    @(negedge clk);
    chk("r error clr", cfg_error, 1'b0);
    chk("r ready", cfg_ready, 1'b1);
    chk("r no aw", awvalid, 1'b0);
    @(negedge clk);
    chk("r no aw2", awvalid, 1'b0);

    // reset during W beat 5
    v = mkvec(12);
    do_start(32'h4000, 32'd64);
    do_data(v);
    do_aw(32'h4000, 0);
    do_w(v, 1'b0, 5);
    chk("x wvalid pre", wvalid, 1'b1);
    chk("x wdata pre", wdata, v[5*32 +: 32]);
    rst_n = 1'b0;
    #1;
    chk_reset("xrst");
    @(negedge clk);
    rst_n = 1'b1;
    v = mkvec(13);
    do_start(32'h5000, 32'd64);
    do_data(v);
    do_aw(32'h5000, 0);
    do_w(v, 1'b0, 16);
    do_b(2'b00, 0);
    chk("x done", cfg_done, 1'b1);
    @(negedge clk);
    chk("x ready", cfg_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
